// File: rtl/rv_pkg.sv
// Shared RV32 pipeline definitions: data width, bubble encoding, reset PC, IF/ID record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   XLEN             - architectural register / address width
//   NOP_INSTR        - bubble instruction, addi x0,x0,0
//   DEFAULT_RESET_PC - PC loaded on reset unless a stage overrides it
//   if_id_t          - packed IF/ID pipeline record
//   next_sel_e       - next-state selector used by the fetch stage
//   word_align()     - clears the two byte-offset bits of an address
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One IF/ID pipeline slot. pc_plus4 is carried so decode never re-adds.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } if_id_t;

  // Resolved next-state action, listed in priority order.
  typedef enum logic [1:0] {
    NEXT_RESET    = 2'd0,
    NEXT_REDIRECT = 2'd1,
    NEXT_HOLD     = 2'd2,
    NEXT_ADVANCE  = 2'd3
  } next_sel_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds one fetched instruction with its PC and PC+4.
// Latency: one edge from load to outputs.
// Backpressure: hold (no load, no flush) freezes every field; flush beats load.
//
// Ports:
//   clk, reset       - rising-edge clock, synchronous active-high reset
//   load             - capture load_pc / load_pc_plus4 / load_instr as a valid slot
//   flush            - replace contents with a bubble (valid=0, instr=NOP_INSTR, pcs=0)
//   load_*           - incoming slot contents
//   valid, pc,
//   pc_plus4, instr  - registered slot contents
module if_id_reg
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_pc_plus4,
  input  logic [XLEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] instr
);

  if_id_t slot_q;
  if_id_t bubble;
  if_id_t incoming;

  // Reset and flush both leave a bubble, so an invalid slot always shows NOP.
  assign bubble   = '{valid: 1'b0, pc: '0, pc_plus4: '0, instr: NOP_INSTR};
  assign incoming = '{valid: 1'b1, pc: load_pc, pc_plus4: load_pc_plus4, instr: load_instr};

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      slot_q <= bubble;
    end else if (load) begin
      slot_q <= incoming;
    end
  end

  assign valid    = slot_q.valid;
  assign pc       = slot_q.pc;
  assign pc_plus4 = slot_q.pc_plus4;
  assign instr    = slot_q.instr;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC mux and IF/ID register.
// Latency: imem_addr is pc_q with zero delay; fetched word lands in IF/ID at the next edge.
// Backpressure: stall freezes pc_q, IF/ID and fetch_count; redirect overrides stall.
//
// Ports:
//   clk, reset             - rising-edge clock, synchronous active-high reset
//   imem_addr, imem_rdata  - asynchronous-read instruction ROM interface
//   stall                  - hold request from decode
//   redirect_valid/_target - taken branch / jump to a new fetch address
//   if_id_*                - IF/ID register outputs toward decode
//   misalign_err           - sticky: a redirect target had nonzero byte offset
//   fetch_count            - number of valid instructions loaded into IF/ID
module if_stage
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [XLEN-1:0] if_id_instr,
  output logic            misalign_err,
  output logic [XLEN-1:0] fetch_count
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_next;
  next_sel_e       next_sel;
  logic            redirect_misaligned;

  // Wraps modulo 2^32; crossing the top of the address space is not an error.
  assign pc_plus4 = pc_q + 32'd4;

  // The ROM address comes only from the PC register, so there is no
  // combinational loop from imem_rdata back to imem_addr.
  assign imem_addr = pc_q;

  assign redirect_misaligned = redirect_target[1:0] != 2'b00;

  // Priority: reset > redirect > stall > advance.
  always_comb begin
    next_sel = NEXT_ADVANCE;
    if (reset) begin
      next_sel = NEXT_RESET;
    end else if (redirect_valid) begin
      next_sel = NEXT_REDIRECT;
    end else if (stall) begin
      next_sel = NEXT_HOLD;
    end
  end

  always_comb begin
    pc_next = pc_q;
    case (next_sel)
      NEXT_RESET:    pc_next = RESET_PC;
      NEXT_REDIRECT: pc_next = word_align(redirect_target);
      NEXT_HOLD:     pc_next = pc_q;
      NEXT_ADVANCE:  pc_next = pc_plus4;
      default:       pc_next = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_next;
  end

  // Only real loads count; holds, flushes and reset cycles do not.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (next_sel == NEXT_ADVANCE) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  // Sticky until reset; the PC still proceeds from the word-aligned target.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else if (redirect_valid && redirect_misaligned) begin
      misalign_err <= 1'b1;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk           (clk),
    .reset         (reset),
    .load          (next_sel == NEXT_ADVANCE),
    .flush         (next_sel == NEXT_REDIRECT),
    .load_pc       (pc_q),
    .load_pc_plus4 (pc_plus4),
    .load_instr    (imem_rdata),
    .valid         (if_id_valid),
    .pc            (if_id_pc),
    .pc_plus4      (if_id_pc_plus4),
    .instr         (if_id_instr)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural asynchronous ROM.
// ROM words 0..63 hold 32'hC0DE_0000 + index; any address above 0xFF reads ~addr.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int vectors;
  int miscompares;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_instr     (if_id_instr),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr[31:8] == 24'd0) imem_rdata = 32'hC0DE_0000 + {26'd0, imem_addr[7:2]};
    else                          imem_rdata = ~imem_addr;
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0042;
    tick();
    tick();
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_pc got=%h exp=%h", imem_addr, 32'h0); end
    vectors++; if (if_id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    vectors++; if (if_id_instr !== 32'h13) begin miscompares++; $display("FAIL reset_instr got=%h exp=00000013", if_id_instr); end
    vectors++; if (if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL reset_ifid_pc got=%h/%h exp=0/0", if_id_pc, if_id_pc_plus4); end
    vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
    vectors++; if (fetch_count !== 32'h0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
  endtask

  task automatic test_sequential();
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    for (int k = 0; k < 8; k++) begin
      tick();
      vectors++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * k) || if_id_pc_plus4 !== 32'(4 * k + 4)
          || if_id_instr !== 32'hC0DE_0000 + 32'(k)) begin
        miscompares++;
        $display("FAIL seq_load%0d got v=%b pc=%h pc4=%h instr=%h exp v=1 pc=%h pc4=%h instr=%h",
                 k, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr,
                 32'(4 * k), 32'(4 * k + 4), 32'hC0DE_0000 + 32'(k));
      end
      vectors++; if (fetch_count !== 32'(k + 1)) begin miscompares++; $display("FAIL seq_count%0d got=%0d exp=%0d", k, fetch_count, k + 1); end
    end
    vectors++; if (imem_addr !== 32'h20) begin miscompares++; $display("FAIL seq_next_addr got=%h exp=00000020", imem_addr); end
  endtask

  task automatic test_stall();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL stall_setup got=%h exp=00000010", imem_addr); end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (imem_addr !== 32'h10 || if_id_pc !== 32'hC || if_id_instr !== 32'hC0DE_0003 || if_id_valid !== 1'b1 || fetch_count !== 32'd4) begin
        miscompares++;
        $display("FAIL stall_hold%0d got addr=%h pc=%h instr=%h v=%b cnt=%0d exp addr=00000010 pc=0000000c instr=c0de0003 v=1 cnt=4",
                 k, imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count);
      end
    end
    stall = 1'b0;
    tick();
    vectors++;
    if (if_id_pc !== 32'h10 || imem_addr !== 32'h14 || fetch_count !== 32'd5) begin
      miscompares++;
      $display("FAIL stall_resume got pc=%h addr=%h cnt=%0d exp pc=00000010 addr=00000014 cnt=5", if_id_pc, imem_addr, fetch_count);
    end
  endtask

  task automatic test_redirect_under_stall();
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    vectors++;
    if (imem_addr !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13 || if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin
      miscompares++;
      $display("FAIL redir_flush got addr=%h v=%b instr=%h pc=%h pc4=%h exp addr=00000040 v=0 instr=00000013 pc=0 pc4=0",
               imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4);
    end
    vectors++; if (fetch_count !== 32'd5 || misalign_err !== 1'b0) begin miscompares++; $display("FAIL redir_side got cnt=%0d err=%b exp cnt=5 err=0", fetch_count, misalign_err); end
    stall = 1'b0; redirect_valid = 1'b0;
    tick();
    vectors++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40 || if_id_instr !== 32'hC0DE_0010 || fetch_count !== 32'd6) begin
      miscompares++;
      $display("FAIL redir_target_load got v=%b pc=%h instr=%h cnt=%0d exp v=1 pc=00000040 instr=c0de0010 cnt=6",
               if_id_valid, if_id_pc, if_id_instr, fetch_count);
    end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_target = 32'h42;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (imem_addr !== 32'h40) begin miscompares++; $display("FAIL misalign_pc got=%h exp=00000040", imem_addr); end
    vectors++; if (misalign_err !== 1'b1) begin miscompares++; $display("FAIL misalign_set got=%b exp=1", misalign_err); end
    for (int k = 0; k < 3; k++) tick();
    vectors++; if (misalign_err !== 1'b1) begin miscompares++; $display("FAIL misalign_sticky got=%b exp=1", misalign_err); end
  endtask

  task automatic test_pc_wrap();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_setup got=%h exp=fffffffc", imem_addr); end
    tick();
    vectors++;
    if (if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'h0 || imem_addr !== 32'h0 || if_id_instr !== 32'h0000_0003) begin
      miscompares++;
      $display("FAIL wrap_advance got pc=%h pc4=%h addr=%h instr=%h exp pc=fffffffc pc4=0 addr=0 instr=00000003",
               if_id_pc, if_id_pc_plus4, imem_addr, if_id_instr);
    end
  endtask

  task automatic test_reset_mid_run();
    reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80; stall = 1'b0;
    tick();
    vectors++;
    if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13 || fetch_count !== 32'h0 || misalign_err !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset got addr=%h v=%b instr=%h cnt=%0d err=%b exp addr=0 v=0 instr=00000013 cnt=0 err=0",
               imem_addr, if_id_valid, if_id_instr, fetch_count, misalign_err);
    end
    reset = 1'b0; redirect_valid = 1'b0;
    tick();
    vectors++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== 32'hC0DE_0000 || fetch_count !== 32'd1) begin
      miscompares++;
      $display("FAIL midreset_first got v=%b pc=%h instr=%h cnt=%0d exp v=1 pc=0 instr=c0de0000 cnt=1",
               if_id_valid, if_id_pc, if_id_instr, fetch_count);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_under_stall();
    test_misalign();
    test_pc_wrap();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
- REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
- REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, giving the bubble instruction (addi x0,x0,0).
- REQ-003 clk  input  1  rising-edge clock.
- REQ-004 reset  input  1  reset, synchronous, active-high.
- REQ-005 imem_addr  output  32  byte address to instruction ROM.
- REQ-006 imem_rdata  input  32  instruction word, combinationally valid in the same cycle as imem_addr.
- REQ-007 stall  input  1  hazard hold request from decode.
- REQ-008 redirect_valid  input  1  taken-branch/jump request.
- REQ-009 redirect_target  input  32  new fetch address.
- REQ-010 if_id_valid  output  1  IF/ID register holds a real instruction.
- REQ-011 if_id_pc  output  32  PC of the held instruction.
- REQ-012 if_id_pc_plus4  output  32  if_id_pc + 4.
- REQ-013 if_id_instr  output  32  held instruction word.
- REQ-014 misalign_err  output  1  sticky flag, set on a misaligned redirect.
- REQ-015 fetch_count  output  32  count of valid instructions loaded into IF/ID.

Function
- REQ-016 imem_addr SHALL equal pc_q combinationally, with zero-cycle address latency.
- REQ-017 The next-state priority SHALL be: reset > redirect_valid > stall > normal advance.
- REQ-018 On a normal advance (no redirect, no stall), the block SHALL load IF/ID with {valid=1, pc_q, pc_q+4, imem_rdata} and set pc_q <= pc_q+4.
- REQ-019 On stall without redirect, pc_q, all IF/ID fields and fetch_count SHALL hold their values unchanged.
- REQ-020 On redirect_valid, the block SHALL set pc_q <= {redirect_target[31:2],2'b00} and flush IF/ID to {valid=0, instr=NOP_INSTR, pc=0, pc_plus4=0}, even when stall is high.
- REQ-021 When a redirect has redirect_target[1:0] != 0, the block SHALL set misalign_err to 1 and keep it at 1 until reset.
- REQ-022 Redirect SHALL take effect at the next edge: the first instruction fetched from the target appears in IF/ID two edges after the redirect cycle.
- REQ-023 PC addition SHALL be 32-bit modulo: pc_q of 32'hFFFF_FFFC SHALL advance to 32'h0000_0000 with no flag.
- REQ-024 fetch_count SHALL increment only on a normal advance and SHALL wrap from 32'hFFFF_FFFF to 0.
- REQ-025 if_id_instr SHALL equal NOP_INSTR whenever if_id_valid is 0.

Reset
- REQ-026 When reset is high at a rising edge, the block SHALL set: pc_q=RESET_PC, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, misalign_err=0, fetch_count=0.
- REQ-027 Reset SHALL override simultaneous redirect_valid and stall.
- REQ-028 The first valid IF/ID load SHALL occur at the first edge after reset deasserts and SHALL carry pc=RESET_PC.
- REQ-029 During reset, imem_addr SHALL show RESET_PC from the first edge onward; the ROM output is ignored.

Structure
- REQ-030 XLEN (32), NOP_INSTR and the default RESET_PC SHALL live in shared package rv_pkg.
- REQ-031 The IF/ID register (valid/pc/pc_plus4/instr, with load/hold/flush controls) SHALL be a sub-module named if_id_reg; the PC register and next-PC mux remain in if_stage.
- REQ-032 The design SHALL have no latches and no combinational path from imem_rdata to imem_addr.

Verification
- REQ-033 Reset release, ROM preloaded at words 0..7, no stall: successive IF/ID pcs SHALL be 0,4,8,..., instr SHALL equal Memory[pc>>2], and fetch_count SHALL read 8 after 8 loads.
- REQ-034 Stall held 3 cycles at pc_q=0x10: imem_addr and IF/ID SHALL hold for 3 cycles, fetch_count SHALL be unchanged, and advance SHALL resume to 0x14.
- REQ-035 Redirect to 0x40 while stall=1: next cycle pc_q SHALL be 0x40 and if_id_valid=0/instr=0x13; the following edge SHALL load pc 0x40.
- REQ-036 Redirect to 0x42: pc_q SHALL become 0x40 and misalign_err SHALL rise and stay 1 until reset.
- REQ-037 pc_q forced via redirect to 0xFFFFFFFC: after one advance, IF/ID pc SHALL be 0xFFFFFFFC with pc_plus4=0, and pc_q SHALL be 0.
- REQ-038 Reset asserted together with redirect_valid mid-run: the next state SHALL be pc_q=RESET_PC, IF/ID flushed, fetch_count=0, misalign_err=0.
